btn_event: RTL and testbench

BTN_EVENT -- requirements
Module: btn_event

---
 rtl/btn_event.sv | 123 ++++++++++++
 tb/tb_btn_event.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/btn_event.sv
// Button event decoder: turns a debounced level into press/release/long/repeat strobes.
// Optional auto-repeat in the LONG state is enabled by defining BTN_EVENT_AUTO_REPEAT_EN.
module btn_event #(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        WAIT_REL,
        IDLE,
        PRESSED,
        LONG
    } state_t;

    localparam logic [31:0] LONG_LAST   = 32'(LONG_CYCLES - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("btn_event: LONG_CYCLES and REPEAT_CYCLES must both be at least 2");
    end

    state_t      state;
    state_t      state_next;
    logic [31:0] cnt;
    logic [31:0] cnt_next;
    logic        press_next;
    logic        release_next;
    logic        long_next;
    logic        repeat_next;
    logic        held_next;
    logic [7:0]  count_next;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;
        count_next   = press_count;
        case (state)
            WAIT_REL: begin
                if (!btn_in) state_next = IDLE;
            end
            IDLE: begin
                if (btn_in) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                    cnt_next   = '0;
                    count_next = press_count + 8'd1;
                end
            end
            PRESSED: begin
                // Release is checked first so it wins over a long event on the same edge
                if (!btn_in) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    cnt_next     = '0;
                end else if (cnt == LONG_LAST) begin
                    state_next = LONG;
                    long_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            LONG: begin
                if (!btn_in) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    cnt_next     = '0;
                end else begin
`ifdef BTN_EVENT_AUTO_REPEAT_EN
                    if (cnt == REPEAT_LAST) begin
                        repeat_next = 1'b1;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt + 32'd1;
                    end
`else
                    cnt_next = (REPEAT_LAST == '0) ? '0 : cnt;
`endif
                end
            end
            default: state_next = WAIT_REL;
        endcase
        held_next = (state_next == PRESSED) || (state_next == LONG);
    end

    // Every output is a flop fed from the next-state logic, so btn_in never reaches a pin directly
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= WAIT_REL;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            long_pulse    <= long_next;
            repeat_pulse  <= repeat_next;
            held          <= held_next;
            press_count   <= count_next;
        end
    end

endmodule

// File: tb/tb_btn_event.sv
// Self-checking bench for btn_event: directed button sequences plus random runs,
// compared every cycle against a press-duration model.
module tb_btn_event;

    localparam int LONG_CYCLES   = 10;
    localparam int REPEAT_CYCLES = 4;
`ifdef BTN_EVENT_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    btn_event #(
        .LONG_CYCLES  (LONG_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: "armed" means btn_in has been seen low since reset; h counts edges held since the press edge
    bit       m_armed = 1'b0;
    bit       m_pressed = 1'b0;
    int       m_h = 0;
    logic [7:0] m_count = 8'd0;
    bit       e_press, e_release, e_long, e_repeat;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic modelStep(input bit b, input bit r);
        e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
        if (r) begin
            m_armed = 0; m_pressed = 0; m_h = 0; m_count = 8'd0;
        end else if (!m_pressed) begin
            if (!b) m_armed = 1;
            else if (m_armed) begin
                m_pressed = 1; m_h = 0; e_press = 1; m_count = m_count + 8'd1;
            end
        end else if (!b) begin
            m_pressed = 0; e_release = 1;
        end else begin
            m_h++;
            if (m_h == LONG_CYCLES) e_long = 1;
            else if (REP_EN && m_h > LONG_CYCLES && (m_h - LONG_CYCLES) % REPEAT_CYCLES == 0)
                e_repeat = 1;
        end
    endtask

    task automatic applyStimulus(input bit b, input bit r);
        @(negedge clk);
        btn_in = b;
        rst    = r;
        @(posedge clk);
        modelStep(b, r);
        #1;
        checkOutput("press_pulse",   32'(press_pulse),   32'(e_press));
        checkOutput("release_pulse", 32'(release_pulse), 32'(e_release));
        checkOutput("long_pulse",    32'(long_pulse),    32'(e_long));
        checkOutput("repeat_pulse",  32'(repeat_pulse),  32'(e_repeat));
        checkOutput("held",          32'(held),          32'(m_pressed));
        checkOutput("press_count",   32'(press_count),   32'(m_count));
    endtask

    task automatic holdFor(input bit b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(b, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("reset_count", 32'(press_count), 32'd0);
        holdFor(1'b0, 2);

        // Short press: high edges 0-2, low at 3
        holdFor(1'b1, 3);
        holdFor(1'b0, 3);
        checkOutput("short_count", 32'(press_count), 32'd1);

        // Long hold with repeats: high edges 0-29, low at 30
        holdFor(1'b1, 30);
        holdFor(1'b0, 3);

        // Release exactly on the long boundary: high edges 0-9, low at 10
        holdFor(1'b1, 10);
        holdFor(1'b0, 3);

        // Counter wrap: reset, then 256 and 257 short presses
        applyStimulus(1'b0, 1'b1);
        holdFor(1'b0, 1);
        for (int p = 0; p < 256; p++) begin
            holdFor(1'b1, 1);
            holdFor(1'b0, 1);
        end
        checkOutput("wrap_256", 32'(press_count), 32'd0);
        holdFor(1'b1, 1);
        holdFor(1'b0, 1);
        checkOutput("wrap_257", 32'(press_count), 32'd1);

        // Reset while in LONG with the button still held
        holdFor(1'b1, 14);
        applyStimulus(1'b1, 1'b1);
        checkOutput("rst_held", 32'(held), 32'd0);
        holdFor(1'b1, 5);
        checkOutput("no_press_after_rst", 32'(press_count), 32'd0);
        holdFor(1'b0, 1);
        holdFor(1'b1, 1);
        checkOutput("press_after_low", 32'(press_pulse), 32'd1);
        holdFor(1'b0, 2);

        // Random level runs with occasional resets
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 19) == 0) applyStimulus(1'($urandom_range(0, 1)), 1'b1);
            holdFor(1'($urandom_range(0, 1)), int'($urandom_range(1, 35)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
